// File: rtl/edge_event_recorder_pkg.sv
// Shared types for the edge event recorder: FSM states and the
// captured {timestamp, data} entry.
package edge_event_pkg;

  localparam int EV_TS_W   = 32;
  localparam int EV_DATA_W = 32;

  typedef enum logic [1:0] {
    WARMUP,
    ARMED,
    PAUSED
  } ev_state_e;

  typedef struct packed {
    logic [EV_TS_W-1:0]   ts;
    logic [EV_DATA_W-1:0] data;
  } ev_entry_t;

endpackage

// File: rtl/edge_event_recorder_if.sv
// Valid/ready event port from the recorder to the downstream
// display/log consumer.
interface edge_event_recorder_if #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 32
);

  logic              ev_valid;
  logic              ev_ready;
  logic [TS_W-1:0]   ev_ts;
  logic [DATA_W-1:0] ev_data;

  modport master (
    output ev_valid,
    output ev_ts,
    output ev_data,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_ts,
    input  ev_data,
    output ev_ready
  );

endinterface

// File: rtl/edge_event_recorder_fifo.sv
// Synchronous FIFO of ev_entry_t; read data is the current head,
// a push becomes visible one cycle later.
module ev_sync_fifo
  import edge_event_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  ev_entry_t din,
  input  logic      pop,
  output ev_entry_t dout,
  output logic      full,
  output logic      empty,
  output logic [AW:0] level
);

  ev_entry_t   mem [DEPTH];
  logic [AW:0] wr_cnt;
  logic [AW:0] rd_cnt;
  logic        do_push;
  logic        do_pop;

  // One extra count bit separates full from empty; the low bits index mem.
  assign level   = wr_cnt - rd_cnt;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_cnt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + 1'b1;
      if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_cnt[AW-1:0]] <= din;
  end

endmodule

// File: rtl/edge_event_recorder.sv
// Records rising edges of watch_data[0] as {ts, data} events into a FIFO.
// Define EVT_DROP_CNT_EN to add the saturating drop_cnt output.
module edge_event_recorder
  import edge_event_pkg::*;
#(
  parameter  int DATA_W = EV_DATA_W,
  parameter  int TS_W   = EV_TS_W,
  parameter  int DEPTH  = 8,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] watch_data,
  edge_event_recorder_if.master ev,
  output logic [LW-1:0]     ev_level,
  output logic              overflow
`ifdef EVT_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  ev_state_e       state;
  ev_state_e       nstate;
  logic            prev_lsb;
  logic [TS_W-1:0] ts;
  logic            evt;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;
  ev_entry_t       din;
  ev_entry_t       head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WARMUP;
      ts       <= '0;
      prev_lsb <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= nstate;
      ts       <= ts + 1'b1;
      prev_lsb <= watch_data[0];
      if (drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    nstate = state;
    evt    = 1'b0;
    unique case (state)
      WARMUP: nstate = en ? ARMED : PAUSED;
      ARMED: begin
        evt = ~prev_lsb & watch_data[0];
        if (!en) nstate = PAUSED;
      end
      PAUSED: if (en) nstate = ARMED;
      default: nstate = WARMUP;
    endcase
  end

  assign din.ts   = ts;
  assign din.data = watch_data;
  assign pop      = ev.ev_valid & ev.ev_ready;
  assign drop     = evt & full & ~pop;

  ev_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (ev_level)
  );

  // Head fields read as zero while empty so reset leaves clean outputs.
  assign ev.ev_valid = ~empty;
  assign ev.ev_ts    = empty ? '0 : head.ts;
  assign ev.ev_data  = empty ? '0 : head.data;

`ifdef EVT_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_edge_event_recorder.sv
// Randomized self-checking bench for edge_event_recorder against a
// queue-based event model.
module tb_edge_event_recorder;
  import edge_event_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] watch_data = '0;
  logic [3:0]  ev_level;
  logic        overflow;
`ifdef EVT_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  edge_event_recorder_if #(.DATA_W(32), .TS_W(32)) ev ();

  edge_event_recorder #(.DATA_W(32), .TS_W(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .watch_data (watch_data),
    .ev         (ev),
    .ev_level   (ev_level),
    .overflow   (overflow)
`ifdef EVT_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Model: an event is a 0->1 LSB step between two consecutive
  // non-reset cycles where en was high on the earlier one.
  ev_entry_t   q[$];
  logic [31:0] m_ts  = '0;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;
  bit          p_rst = 1'b1;
  bit          p_en  = 1'b0;
  bit          p_lsb = 1'b0;

  task automatic check_outs();
    chk("valid", ev.ev_valid, q.size() > 0);
    chk("level", ev_level, q.size());
    if (q.size() > 0) begin
      chk("ts", ev.ev_ts, q[0].ts);
      chk("data", ev.ev_data, q[0].data);
    end else begin
      chk("ts_idle", ev.ev_ts, 0);
      chk("data_idle", ev.ev_data, 0);
    end
    chk("overflow", overflow, m_ovf);
`ifdef EVT_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, m_drop);
`endif
  endtask

  task automatic model_step(input bit r, input bit e,
                            input logic [31:0] w, input bit rd);
    bit        edge_seen;
    ev_entry_t ent;
    if (r) begin
      q.delete();
      m_ts   = '0;
      m_ovf  = 1'b0;
      m_drop = 0;
      p_rst  = 1'b1;
    end else begin
      edge_seen = !p_rst && p_en && !p_lsb && w[0];
      if (q.size() > 0 && rd) void'(q.pop_front());
      if (edge_seen) begin
        if (q.size() < DEPTH) begin
          ent.ts   = m_ts;
          ent.data = w;
          q.push_back(ent);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      m_ts  = m_ts + 1;
      p_rst = 1'b0;
    end
    p_en  = e;
    p_lsb = w[0];
  endtask

  task automatic cyc(input bit r, input bit e,
                     input logic [31:0] w, input bit rd);
    @(negedge clk);
    check_outs();
    rst         = r;
    en          = e;
    watch_data  = w;
    ev.ev_ready = rd;
    model_step(r, e, w, rd);
  endtask

  task automatic do_reset();
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
  endtask

  initial begin
    int pr;
    ev.ev_ready = 1'b0;
    do_reset();
    // Counter source, free-flowing consumer
    for (int i = 0; i < 40; i++) cyc(0, 1, i, 1);
    // Stalled consumer fills FIFO, then pop+push on an edge
    do_reset();
    for (int i = 0; i <= 20; i++) cyc(0, 1, i, 0);
    for (int i = 21; i < 32; i++) cyc(0, 1, i, 1);
    // Toggle LSB while disabled, re-enable with LSB already high
    for (int i = 0; i < 10; i++) cyc(0, 0, i, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 1, 1);
    // LSB high at reset release
    cyc(1, 1, 1, 1);
    cyc(1, 1, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1);
    cyc(0, 1, 2, 1);
    cyc(0, 1, 3, 1);
    cyc(0, 1, 3, 1);
    // Reset with entries queued
    do_reset();
    for (int i = 0; i < 10; i++) cyc(0, 1, i, 0);
    cyc(1, 1, 10, 0);
    cyc(0, 1, 11, 0);
    cyc(0, 1, 12, 1);
    cyc(0, 1, 13, 1);
    // Random traffic with varying consumer pressure
    for (int b = 0; b < 12; b++) begin
      pr = $urandom_range(0, 3);
      for (int i = 0; i < 250; i++) begin
        cyc($urandom_range(0, 299) == 0,
            $urandom_range(0, 9) != 0,
            $urandom,
            $urandom_range(0, 3) < pr);
      end
    end
    @(negedge clk);
    check_outs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
